mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports as follows; one clock; reset is synchronous and active-high.
- CLOCK_50  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0/req1  in  1  access request from port 0 (processor) and port 1 (debug/loader), level, held until grant.
- we0/we1  in  1  1 = write, 0 = read; sampled with req.
- addr0/addr1  in  8  byte address.
- wdata0/wdata1  in  8  write data.
- gnt0/gnt1  out  1  one-cycle grant pulse; marks the ACC cycle.
- rvalid0/rvalid1  out  1  one-cycle read-data-valid pulse.
- rdata  out  8  read data, shared by both ports; meaningful only while rvalid0 or rvalid1 is high.
- mem_addr, mem_wdata  out  8  to the single-port 256x8 memory.
- mem_read, mem_write  out  1  memory strobes; the memory has 1-cycle read latency.
- mem_rdata  in  8  memory read data.
- busy  out  1  high in any state other than IDLE.

Function
REQ-002 SHALL implement the FSM states IDLE, ACC and RSP.
REQ-003 IDLE: if any req is high at the edge, latch the winner's we/addr/wdata and go to ACC; otherwise stay in IDLE.
REQ-004 ACC: drive mem_addr and mem_wdata from the latched values, mem_write = we and mem_read = ~we, and gntN = 1 for the winner; next state is RSP for a read and IDLE for a write.
REQ-005 RSP: rvalidN = 1 for the read winner, rdata = mem_rdata; then arbitrate exactly as in IDLE (ACC if a req is pending, else IDLE).
REQ-006 Latency: a write takes 2 cycles from req sampled to memory write; a read takes 3 cycles (sample, ACC, RSP).
REQ-007 req is ignored during ACC; a requester SHALL deassert req in the cycle after its gnt, or a further access is granted.
REQ-008 Arbitration (default) SHALL be round-robin: when both ports request, the port not granted last wins; a single requester always wins.
REQ-009 The last-grant pointer SHALL update only on entry to ACC.
REQ-010 At most one gnt, one rvalid and one memory strobe SHALL be high in any cycle; mem_read and mem_write are never high together.
REQ-011 All outputs SHALL be decoded from registered state and latched fields, with no combinational path from req to gnt.
REQ-012 Address wrap is not applicable: the full 8-bit space is passed through unchanged; addr 8'hFF is legal.
REQ-013 When both requests are sampled high simultaneously, the loser's req SHALL remain pending and be served on the next arbitration point, with no loss.

Reset
REQ-014 While reset is high at an edge, the next state SHALL be IDLE, the latched fields 0 and the pointer set so that port 0 wins the first tie.
REQ-015 After the reset edge, gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write and busy SHALL be 0, and rdata, mem_addr and mem_wdata SHALL be 8'h00.
REQ-016 Reset mid-operation: a strobe already present in the reset cycle completes at that edge; no gnt or rvalid SHALL follow reset, and a pending read response SHALL be dropped.

Configuration
REQ-017 Macro MEM_ARB_FIXED_PRIO_EN: when defined, port 0 SHALL always win ties and the pointer is removed; when undefined, the round-robin of REQ-008 applies. Ports and timing SHALL be identical in both builds.

Structure
REQ-018 A shared package mem_arb_pkg SHALL hold the state encoding (IDLE/ACC/RSP), the port index constants PORT0/PORT1, and the widths ADDR_W = 8 and DATA_W = 8.
REQ-019 A sub-module mem_arb_rr_sel SHALL compute the winner from req0, req1 and the pointer; it is bypassed when MEM_ARB_FIXED_PRIO_EN is defined.

Verification
REQ-020 The bench SHALL cover the following scenarios:
- Single write: req1 = 1, we1 = 1, addr1 = 8'h10, wdata1 = 8'hA5 for one cycle -> next cycle gnt1 = 1, mem_write = 1, mem_addr = 8'h10, mem_wdata = 8'hA5.
- Read-back: req0 read of 8'h10 -> gnt0 in cycle +1, then rvalid0 = 1 with rdata = 8'hA5 in cycle +2.
- Tie, round-robin: req0 and req1 high every cycle, both reads, out of reset -> grant order 0,1,0,1 with no idle cycle between RSP and the next ACC.
- Tie with MEM_ARB_FIXED_PRIO_EN defined: same stimulus -> gnt0 on every grant; port 1 is served only once req0 drops.
- Reset during RSP of a read from 8'h20 -> rvalid stays 0; the next cycle shows busy = 0 and all strobes 0.
- Address 8'hFF write followed by read -> value returned intact; check no illegal overlap of any two strobes in any cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, port
// indices and datapath widths.
package mem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RSP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_rr_sel.sv
// Round-robin winner select for two requesters: on a tie the port that was
// not granted last wins; a lone requester always wins.
module mem_arb_rr_sel
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic any_req,
    output logic winner
);

    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = PORT1;
        end else begin
            winner = PORT0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port 256x8 memory with 1-cycle read
// latency. Define MEM_ARB_FIXED_PRIO_EN to make port 0 win every tie.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              lat_we;
    logic              lat_port;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              any_req;
    logic              winner;
    logic              take;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign any_req = req0 | req1;
    assign winner  = req0 ? PORT0 : PORT1;
`else
    logic last;

    mem_arb_rr_sel u_rr_sel (
        .req0    (req0),
        .req1    (req1),
        .last    (last),
        .any_req (any_req),
        .winner  (winner)
    );

    // Reset to PORT1 so that port 0 takes the first tie.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            last <= PORT1;
        end else if (take) begin
            last <= winner;
        end
    end
`endif

    // Requests are only looked at outside ACC; taking one always enters ACC.
    assign take = (state != ACC) && any_req;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_port  <= PORT0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                lat_port  <= winner;
                lat_we    <= (winner == PORT1) ? we1    : we0;
                lat_addr  <= (winner == PORT1) ? addr1  : addr0;
                lat_wdata <= (winner == PORT1) ? wdata1 : wdata0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RSP: state_nxt = any_req ? ACC : IDLE;
            ACC:       state_nxt = lat_we ? IDLE : RSP;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        rdata     = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        busy      = (state != IDLE);
        if (state == ACC) begin
            gnt0      = (lat_port == PORT0);
            gnt1      = (lat_port == PORT1);
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            mem_write = lat_we;
            mem_read  = ~lat_we;
        end
        if (state == RSP) begin
            rvalid0 = (lat_port == PORT0);
            rvalid1 = (lat_port == PORT1);
            rdata   = mem_rdata;
        end
    end

endmodule
